// File: rtl/doppler_peak_search_if.sv
// -----------------------------------------------------------------------------
// doppler_peak_search_if
// Bundles the spectrum sample stream feeding the peak search and the per-bin
// result bus it produces.
//   spec_data_i / spec_valid_i / spec_sop_i : accumulated power stream
//   peak_valid_o                             : one-cycle result strobe
//   peak_idx_o / peak_val_o                  : index and power of the maximum
//   peak_left_o / peak_right_o               : neighbour powers (0 at edges)
//   bin_num_o / frame_done_o                 : range-bin number, last-bin pulse
//   no_peak_o                                : search window was empty
//   sop_err_o                                : sticky mid-spectrum SOP flag
// Modports: master = stream source / result sink, slave = peak search block.
// -----------------------------------------------------------------------------
interface doppler_peak_search_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 9
);
    logic [DATA_W-1:0] spec_data_i;
    logic              spec_valid_i;
    logic              spec_sop_i;
    logic              peak_valid_o;
    logic [IDX_W-1:0]  peak_idx_o;
    logic [DATA_W-1:0] peak_val_o;
    logic [DATA_W-1:0] peak_left_o;
    logic [DATA_W-1:0] peak_right_o;
    logic [15:0]       bin_num_o;
    logic              no_peak_o;
    logic              frame_done_o;
    logic              sop_err_o;

    modport master (
        output spec_data_i, spec_valid_i, spec_sop_i,
        input  peak_valid_o, peak_idx_o, peak_val_o, peak_left_o, peak_right_o,
        input  bin_num_o, no_peak_o, frame_done_o, sop_err_o
    );

    modport slave (
        input  spec_data_i, spec_valid_i, spec_sop_i,
        output peak_valid_o, peak_idx_o, peak_val_o, peak_left_o, peak_right_o,
        output bin_num_o, no_peak_o, frame_done_o, sop_err_o
    );
endinterface

// File: rtl/doppler_peak_search.sv
// -----------------------------------------------------------------------------
// doppler_peak_search
// Scans each range bin's accumulated power spectrum (index 0..NHALF-1) and
// reports the maximum inside the window [lo_lim_i, hi_lim_i] together with
// its two neighbours, the range-bin number and a frame-done pulse.
// Ports:
//   clk_i, rst_i (async, active-high)
//   enable_i            : low forces IDLE, discards partial scan, clears bin count
//   lo_lim_i, hi_lim_i  : search window (inclusive), latched at SOP of bin 0
//   n_bins_i            : range bins per frame (0 treated as 1), latched likewise
//   bus (slave)         : sample stream in, result bus out
// -----------------------------------------------------------------------------
module doppler_peak_search #(
    parameter int DATA_W = 64,
    parameter int NHALF  = 512,
    parameter int IDX_W  = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [15:0] lo_lim_i,
    input  logic [15:0] hi_lim_i,
    input  logic [15:0] n_bins_i,
    doppler_peak_search_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NHALF - 1);
    localparam logic [15:0]      HI_MAX   = 16'(NHALF - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;        // index of the next expected sample
    logic [15:0]       r_bin;
    logic [15:0]       r_lo;
    logic [15:0]       r_hi;         // already clamped to NHALF-1
    logic [15:0]       r_nbins;      // already forced to at least 1
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_pidx;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;
    logic              r_found;
    logic              r_pend;

    logic              r_peak_valid;
    logic [IDX_W-1:0]  r_peak_idx;
    logic [DATA_W-1:0] r_peak_val;
    logic [DATA_W-1:0] r_peak_left;
    logic [DATA_W-1:0] r_peak_right;
    logic [15:0]       r_bin_num;
    logic              r_no_peak;
    logic              r_frame_done;
    logic              r_sop_err;

    logic              w_accept;
    logic              w_start;
    logic              w_sample;
    logic [IDX_W-1:0]  w_k;
    logic              w_relatch;
    logic [15:0]       w_lo;
    logic [15:0]       w_hi;
    logic [15:0]       w_nbins;
    logic              w_cand;
    logic              w_found_prev;
    logic              w_pend_prev;
    logic              w_update;
    logic              w_last;
    logic [DATA_W-1:0] w_max;
    logic [IDX_W-1:0]  w_pidx;
    logic [DATA_W-1:0] w_left;
    logic [DATA_W-1:0] w_right;
    logic              w_found;
    logic              w_pend;
    logic              w_frame_end;

    // Sample acceptance, window limits and candidate qualification
    always_comb begin
        w_accept  = bus.spec_valid_i & enable_i;
        w_start   = w_accept & bus.spec_sop_i;
        // In IDLE only an SOP sample is taken; in SCAN every valid sample is
        w_sample  = (r_state == SCAN) ? w_accept : w_start;
        // An SOP always restarts the spectrum at index 0
        w_k       = bus.spec_sop_i ? '0 : r_idx;
        w_relatch = w_start & (r_bin == 16'd0);
        if (w_relatch) begin
            w_lo    = lo_lim_i;
            w_hi    = (hi_lim_i > HI_MAX) ? HI_MAX : hi_lim_i;
            w_nbins = (n_bins_i == 16'd0) ? 16'd1 : n_bins_i;
        end else begin
            w_lo    = r_lo;
            w_hi    = r_hi;
            w_nbins = r_nbins;
        end
        w_cand       = (16'(w_k) >= w_lo) && (16'(w_k) <= w_hi);
        w_found_prev = w_start ? 1'b0 : r_found;
        w_pend_prev  = w_start ? 1'b0 : r_pend;
        // Strictly greater keeps the lowest index on ties
        w_update     = w_cand && (!w_found_prev || (bus.spec_data_i > r_max));
        w_last       = w_sample && (w_k == LAST_IDX);
        w_frame_end  = (r_bin == (w_nbins - 16'd1));
    end

    // Next running-maximum and neighbour values for the current sample
    always_comb begin
        w_max   = r_max;
        w_pidx  = r_pidx;
        w_left  = r_left;
        w_right = r_right;
        w_found = w_found_prev;
        w_pend  = w_pend_prev;
        if (w_update) begin
            w_max   = bus.spec_data_i;
            w_pidx  = w_k;
            w_left  = (w_k == '0) ? '0 : r_prev;
            w_right = '0;
            w_found = 1'b1;
            w_pend  = 1'b1;
        end else if (w_pend_prev) begin
            w_right = bus.spec_data_i;
            w_pend  = 1'b0;
        end else begin
            w_pend  = 1'b0;
        end
    end

    // Scan FSM, running registers and registered result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_bin        <= 16'd0;
            r_lo         <= 16'd0;
            r_hi         <= 16'd0;
            r_nbins      <= 16'd1;
            r_prev       <= '0;
            r_max        <= '0;
            r_pidx       <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_found      <= 1'b0;
            r_pend       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_idx   <= '0;
            r_peak_val   <= '0;
            r_peak_left  <= '0;
            r_peak_right <= '0;
            r_bin_num    <= 16'd0;
            r_no_peak    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sop_err    <= 1'b0;
        end else if (!enable_i) begin
            // Abort: result outputs and the sticky error keep their values
            r_state      <= IDLE;
            r_idx        <= '0;
            r_bin        <= 16'd0;
            r_found      <= 1'b0;
            r_pend       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_sample) begin
                if ((r_state == SCAN) && bus.spec_sop_i) begin
                    r_sop_err <= 1'b1;
                end
                if (w_relatch) begin
                    r_lo    <= w_lo;
                    r_hi    <= w_hi;
                    r_nbins <= w_nbins;
                end
                r_prev  <= bus.spec_data_i;
                r_max   <= w_max;
                r_pidx  <= w_pidx;
                r_left  <= w_left;
                r_right <= w_right;
                r_found <= w_found;
                r_pend  <= w_pend;
                if (w_last) begin
                    r_state      <= IDLE;
                    r_idx        <= '0;
                    r_peak_valid <= 1'b1;
                    r_no_peak    <= ~w_found;
                    r_peak_idx   <= w_found ? w_pidx  : '0;
                    r_peak_val   <= w_found ? w_max   : '0;
                    r_peak_left  <= w_found ? w_left  : '0;
                    r_peak_right <= w_found ? w_right : '0;
                    r_bin_num    <= r_bin;
                    r_frame_done <= w_frame_end;
                    r_bin        <= w_frame_end ? 16'd0 : (r_bin + 16'd1);
                end else begin
                    r_state <= SCAN;
                    r_idx   <= w_k + IDX_W'(1);
                end
            end
        end
    end

    assign bus.peak_valid_o = r_peak_valid;
    assign bus.peak_idx_o   = r_peak_idx;
    assign bus.peak_val_o   = r_peak_val;
    assign bus.peak_left_o  = r_peak_left;
    assign bus.peak_right_o = r_peak_right;
    assign bus.bin_num_o    = r_bin_num;
    assign bus.no_peak_o    = r_no_peak;
    assign bus.frame_done_o = r_frame_done;
    assign bus.sop_err_o    = r_sop_err;

endmodule

// File: tb/tb_doppler_peak_search.sv
// -----------------------------------------------------------------------------
// tb_doppler_peak_search
// Directed, table-driven bench for doppler_peak_search: single-bin window
// vectors from a struct table, then hand-written frame, SOP-abort, enable-drop
// and async-reset sequences.
// -----------------------------------------------------------------------------
module tb_doppler_peak_search;

    localparam int DATA_W = 64;
    localparam int NHALF  = 512;
    localparam int IDX_W  = 9;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] lo_lim_i;
    logic [15:0] hi_lim_i;
    logic [15:0] n_bins_i;

    doppler_peak_search_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    doppler_peak_search #(.DATA_W(DATA_W), .NHALF(NHALF), .IDX_W(IDX_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .lo_lim_i (lo_lim_i),
        .hi_lim_i (hi_lim_i),
        .n_bins_i (n_bins_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    // Count result strobes, sampled away from the active edge
    always @(negedge clk_i) begin
        if (bus.peak_valid_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Spectrum shape: baseline 1 with up to three spikes
    int          g_si [3];
    logic [63:0] g_sv [3];

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        int          i0; logic [63:0] v0;
        int          i1; logic [63:0] v1;
        int          i2; logic [63:0] v2;
        int          e_idx;
        logic [63:0] e_val;
        logic [63:0] e_left;
        logic [63:0] e_right;
        bit          e_np;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] gen(input int k);
        for (int j = 0; j < 3; j++) begin
            if (k == g_si[j]) return g_sv[j];
        end
        return 64'd1;
    endfunction

    task automatic set_spikes(input int i0, input logic [63:0] v0, input int i1, input logic [63:0] v1,
                              input int i2, input logic [63:0] v2);
        g_si[0] = i0; g_sv[0] = v0;
        g_si[1] = i1; g_sv[1] = v1;
        g_si[2] = i2; g_sv[2] = v2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives samples 0..n-1 (sample 0 carries SOP); returns #1 after the last accepting edge
    task automatic send(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && k != 0 && $urandom_range(0, 3) == 0) begin
                bus.spec_valid_i = 1'b0;
                bus.spec_sop_i   = 1'b0;
                bus.spec_data_i  = {$urandom, $urandom};
                @(posedge clk_i); #1;
            end
            bus.spec_valid_i = 1'b1;
            bus.spec_sop_i   = (k == 0);
            bus.spec_data_i  = gen(k);
            @(posedge clk_i); #1;
        end
        bus.spec_valid_i = 1'b0;
        bus.spec_sop_i   = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int e_idx, input logic [63:0] e_val,
                              input logic [63:0] e_l, input logic [63:0] e_r, input bit e_np,
                              input int e_bin, input bit e_fd);
        chk({tag, ".valid"}, 64'(bus.peak_valid_o), 64'd1);
        chk({tag, ".idx"},   64'(bus.peak_idx_o),   64'(e_idx));
        chk({tag, ".val"},   bus.peak_val_o,        e_val);
        chk({tag, ".left"},  bus.peak_left_o,       e_l);
        chk({tag, ".right"}, bus.peak_right_o,      e_r);
        chk({tag, ".nopk"},  64'(bus.no_peak_o),    64'(e_np));
        chk({tag, ".bin"},   64'(bus.bin_num_o),    64'(e_bin));
        chk({tag, ".fdone"}, 64'(bus.frame_done_o), 64'(e_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int p0;
        //          lo      hi      i0  v0     i1  v1     i2  v2    idx val    left right np
        vecs[0] = '{16'd10, 16'd100, 49, 64'd300, 50, 64'd5000, 51, 64'd400, 50, 64'd5000, 64'd300, 64'd400, 1'b0};
        vecs[1] = '{16'd10, 16'd100, 5, 64'd9000, 20, 64'd700, 999, 64'd0, 20, 64'd700, 64'd1, 64'd1, 1'b0};
        vecs[2] = '{16'd10, 16'd100, 30, 64'd800, 60, 64'd800, 999, 64'd0, 30, 64'd800, 64'd1, 64'd1, 1'b0};
        vecs[3] = '{16'd0, 16'd100, 0, 64'd900, 1, 64'd50, 999, 64'd0, 0, 64'd900, 64'd0, 64'd50, 1'b0};
        vecs[4] = '{16'd0, 16'd600, 510, 64'd70, 511, 64'd1000, 999, 64'd0, 511, 64'd1000, 64'd70, 64'd0, 1'b0};
        vecs[5] = '{16'd200, 16'd100, 999, 64'd0, 999, 64'd0, 999, 64'd0, 0, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[6] = '{16'd600, 16'd700, 999, 64'd0, 999, 64'd0, 999, 64'd0, 0, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[7] = '{16'd511, 16'd511, 511, 64'd3, 999, 64'd0, 999, 64'd0, 511, 64'd3, 64'd1, 64'd0, 1'b0};

        rst_i = 1'b1; enable_i = 1'b0;
        lo_lim_i = 16'd0; hi_lim_i = 16'd511; n_bins_i = 16'd1;
        bus.spec_valid_i = 1'b0; bus.spec_sop_i = 1'b0; bus.spec_data_i = 64'd0;
        set_spikes(999, 64'd0, 999, 64'd0, 999, 64'd0);
        idle(3);
        chk("rst.valid", 64'(bus.peak_valid_o), 64'd0);
        chk("rst.idx",   64'(bus.peak_idx_o),   64'd0);
        chk("rst.val",   bus.peak_val_o,        64'd0);
        chk("rst.bin",   64'(bus.bin_num_o),    64'd0);
        chk("rst.fdone", 64'(bus.frame_done_o), 64'd0);
        chk("rst.serr",  64'(bus.sop_err_o),    64'd0);
        rst_i = 1'b0;
        enable_i = 1'b1;
        idle(2);

        // Non-SOP samples in IDLE must be ignored
        p0 = pulse_cnt;
        for (int k = 0; k < 20; k++) begin
            bus.spec_valid_i = 1'b1; bus.spec_sop_i = 1'b0; bus.spec_data_i = 64'd123456;
            @(posedge clk_i); #1;
        end
        bus.spec_valid_i = 1'b0;
        idle(2);
        chk("idle.nopulse", 64'(pulse_cnt - p0), 64'd0);

        // Single-bin window vectors
        for (int v = 0; v < 8; v++) begin
            lo_lim_i = vecs[v].lo; hi_lim_i = vecs[v].hi; n_bins_i = 16'd1;
            set_spikes(vecs[v].i0, vecs[v].v0, vecs[v].i1, vecs[v].v1, vecs[v].i2, vecs[v].v2);
            p0 = pulse_cnt;
            send(NHALF, v[0]);
            chk_result($sformatf("vec%0d", v), vecs[v].e_idx, vecs[v].e_val, vecs[v].e_left,
                       vecs[v].e_right, vecs[v].e_np, 0, 1'b1);
            idle(1);
            chk($sformatf("vec%0d.pulse_end", v), 64'(bus.peak_valid_o), 64'd0);
            chk($sformatf("vec%0d.pulses", v), 64'(pulse_cnt - p0), 64'd1);
        end
        chk("vec.serr", 64'(bus.sop_err_o), 64'd0);

        // Frame of 3 bins, random gaps, back-to-back SOP in each emission cycle
        p0 = pulse_cnt;
        for (int b = 0; b < 4; b++) begin
            if (b == 0 || b == 3) begin
                lo_lim_i = 16'd0; hi_lim_i = 16'd511; n_bins_i = 16'd3;
            end else begin
                // Must be ignored: limits stay latched from bin 0
                lo_lim_i = 16'd400; hi_lim_i = 16'd450; n_bins_i = 16'd7;
            end
            set_spikes(100 + b, 64'(2000 + b), 999, 64'd0, 999, 64'd0);
            send(NHALF, 1'b1);
            chk_result($sformatf("frame.b%0d", b), 100 + b, 64'(2000 + b), 64'd1, 64'd1, 1'b0,
                       (b == 3) ? 0 : b, (b == 2));
        end
        idle(2);
        chk("frame.pulses", 64'(pulse_cnt - p0), 64'd4);
        // Return bin count to 0
        enable_i = 1'b0; idle(1); enable_i = 1'b1; idle(1);

        // SOP at idx 300 aborts the spectrum and restarts it
        lo_lim_i = 16'd0; hi_lim_i = 16'd511; n_bins_i = 16'd2;
        p0 = pulse_cnt;
        set_spikes(100, 64'd9999, 999, 64'd0, 999, 64'd0);
        send(300, 1'b0);
        set_spikes(200, 64'd3000, 999, 64'd0, 999, 64'd0);
        send(NHALF, 1'b0);
        chk_result("sopabort", 200, 64'd3000, 64'd1, 64'd1, 1'b0, 0, 1'b0);
        chk("sopabort.serr", 64'(bus.sop_err_o), 64'd1);
        idle(2);
        chk("sopabort.pulses", 64'(pulse_cnt - p0), 64'd1);

        // Enable dropped at idx 100: no result, outputs hold, bin count cleared
        p0 = pulse_cnt;
        set_spikes(50, 64'd7777, 999, 64'd0, 999, 64'd0);
        send(100, 1'b0);
        enable_i = 1'b0;
        idle(2);
        chk("endrop.hold_idx", 64'(bus.peak_idx_o), 64'd200);
        chk("endrop.hold_val", bus.peak_val_o, 64'd3000);
        chk("endrop.serr", 64'(bus.sop_err_o), 64'd1);
        chk("endrop.pulses", 64'(pulse_cnt - p0), 64'd0);
        enable_i = 1'b1;
        set_spikes(300, 64'd4444, 301, 64'd17, 999, 64'd0);
        send(NHALF, 1'b0);
        chk_result("reen", 300, 64'd4444, 64'd1, 64'd17, 1'b0, 0, 1'b0);
        idle(2);

        // Async reset mid-scan
        p0 = pulse_cnt;
        send(50, 1'b0);
        bus.spec_valid_i = 1'b1; bus.spec_sop_i = 1'b0; bus.spec_data_i = 64'd5;
        #2 rst_i = 1'b1;
        #1;
        chk("arst.serr", 64'(bus.sop_err_o), 64'd0);
        chk("arst.idx",  64'(bus.peak_idx_o), 64'd0);
        chk("arst.val",  bus.peak_val_o, 64'd0);
        idle(2);
        rst_i = 1'b0;
        idle(NHALF);
        chk("arst.pulses", 64'(pulse_cnt - p0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
